// File: rtl/ctrl_sequencer.sv
// Control FSM for the 4-bit accumulator datapath: fetch, decode, execute, memory, writeback.
// Optional single-step PAUSE state enabled by defining CTRL_SINGLE_STEP_EN.
module ctrl_sequencer #(
  parameter int unsigned OPW     = 4,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       o_imem_req,
  input  logic       i_imem_ack,
  input  logic [7:0] i_instr,
  output logic       o_dmem_req,
  output logic       o_dmem_we,
  input  logic       i_dmem_ack,
  input  logic       i_zero_flag,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic       i_step,
`endif
  output logic       o_sel1,
  output logic       o_sel2,
  output logic       o_sel3,
  output logic [1:0] o_alu_op,
  output logic       o_ir_we,
  output logic       o_acc_we,
  output logic       o_pc_en,
  output logic       o_halted,
  output logic       o_err
);

  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StExec, StMem, StWb, StHalt, StPause
  } state_e;

  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       sel1;
    logic       sel2;
    logic       sel3;
    logic [1:0] alu_op;
    logic       acc_we;
    logic       pc_en;
    logic       halted;
    logic       err;
  } outs_t;

  localparam logic [OPW-1:0] OpAdd  = 4'h1;
  localparam logic [OPW-1:0] OpAddi = 4'h2;
  localparam logic [OPW-1:0] OpSub  = 4'h3;
  localparam logic [OPW-1:0] OpSubi = 4'h4;
  localparam logic [OPW-1:0] OpLd   = 4'h5;
  localparam logic [OPW-1:0] OpSt   = 4'h6;
  localparam logic [OPW-1:0] OpJmp  = 4'h7;
  localparam logic [OPW-1:0] OpJz   = 4'h8;
  localparam logic [OPW-1:0] OpHalt = 4'hF;

  // Moore outputs for the state being entered; registered so they line up with that state.
  function automatic outs_t f_moore(state_e st, logic [OPW-1:0] op, logic zf);
    outs_t o;
    o = '0;
    case (st)
      StFetch: o.imem_req = 1'b1;
      StDecode: begin
        case (op)
          OpAdd, OpAddi, OpSub, OpSubi, OpLd, OpSt, OpHalt: o.pc_en = 1'b0;
          OpJmp: begin o.pc_en = 1'b1; o.sel1 = 1'b1; end
          OpJz:  begin o.pc_en = 1'b1; o.sel1 = zf; end
          4'h0:  o.pc_en = 1'b1;
          default: begin o.pc_en = 1'b1; o.err = 1'b1; end
        endcase
      end
      StExec: begin
        o.alu_op = (op == OpAdd || op == OpAddi) ? 2'b01 : 2'b10;
        o.sel2   = (op == OpAddi || op == OpSubi);
        o.acc_we = 1'b1;
        o.pc_en  = 1'b1;
      end
      StMem: begin
        o.dmem_req = 1'b1;
        o.dmem_we  = (op == OpSt);
      end
      StWb: begin
        o.sel3   = 1'b1;
        o.acc_we = 1'b1;
        o.pc_en  = 1'b1;
      end
      StHalt:  o.halted = 1'b1;
      default: o = '0;
    endcase
    return o;
  endfunction

  state_e         r_state;
  logic   [7:0]   r_ir;
  logic   [3:0]   r_cnt;
  outs_t          r_outs;

  state_e         w_next;
  logic   [7:0]   w_ir_next;
  logic [OPW-1:0] w_op;
  logic           w_wait;
  logic           w_tmo;
  logic           w_unused_operand;

  assign w_op             = r_ir[7:8-OPW];
  assign w_unused_operand = ^r_ir[3:0];
  assign w_ir_next        = (r_state == StFetch && i_imem_ack) ? i_instr : r_ir;
  assign w_wait           = (r_state == StFetch && !i_imem_ack) ||
                            (r_state == StMem && !i_dmem_ack);
  assign w_tmo            = w_wait && (r_cnt == 4'(TIMEOUT - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      StIdle:  w_next = StFetch;
      StFetch: begin
        if (i_imem_ack) w_next = StDecode;
        else if (w_tmo) w_next = StIdle;
      end
      StDecode: begin
        case (w_op)
          OpAdd, OpAddi, OpSub, OpSubi: w_next = StExec;
          OpLd, OpSt:                   w_next = StMem;
          OpHalt:                       w_next = StHalt;
          default:                      w_next = StFetch;
        endcase
      end
      StExec, StWb: w_next = StFetch;
      StMem: begin
        if (i_dmem_ack) w_next = (w_op == OpSt) ? StFetch : StWb;
        else if (w_tmo) w_next = StIdle;
      end
      StHalt: w_next = StHalt;
`ifdef CTRL_SINGLE_STEP_EN
      StPause: if (i_step) w_next = StFetch;
`endif
      default: w_next = StIdle;
    endcase
`ifdef CTRL_SINGLE_STEP_EN
    if (w_next == StFetch && r_state inside {StDecode, StExec, StMem, StWb}) w_next = StPause;
`endif
  end

  // Timeouts detour through IDLE so the request visibly drops before the refetch.
  // zero_flag cannot change between FETCH and DECODE, so sampling it on entry is exact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_ir    <= 8'h00;
      r_cnt   <= 4'd0;
      r_outs  <= '0;
    end else begin
      r_state <= w_next;
      r_ir    <= w_ir_next;
      if (w_next != r_state) r_cnt <= 4'd0;
      else if (w_wait)       r_cnt <= r_cnt + 4'd1;
      r_outs  <= f_moore(w_next, w_ir_next[7:8-OPW], i_zero_flag);
    end
  end

  assign o_imem_req = r_outs.imem_req;
  assign o_dmem_req = r_outs.dmem_req;
  assign o_dmem_we  = r_outs.dmem_we;
  assign o_sel1     = r_outs.sel1;
  assign o_sel2     = r_outs.sel2;
  assign o_sel3     = r_outs.sel3;
  assign o_alu_op   = r_outs.alu_op;
  assign o_acc_we   = r_outs.acc_we;
  assign o_halted   = r_outs.halted;
  assign o_ir_we    = (r_state == StFetch) && i_imem_ack;
  assign o_err      = r_outs.err || w_tmo;
  // A store retires on the ack cycle itself, with no writeback state after it.
  assign o_pc_en    = r_outs.pc_en || (r_state == StMem && w_op == OpSt && i_dmem_ack);

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed self-checking bench for ctrl_sequencer (default build, TIMEOUT = 8).
module tb_ctrl_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, zero_flag;
  logic [7:0] instr;
  logic       sel1, sel2, sel3, ir_we, acc_we, pc_en, halted, err;
  logic [1:0] alu_op;
  logic [12:0] obs;

  int n_chk = 0;
  int n_pass = 0;

  localparam logic [12:0] E_IREQ = 13'h1000, E_IRWE = 13'h0800, E_DREQ = 13'h0400;
  localparam logic [12:0] E_DWE  = 13'h0200, E_S1   = 13'h0100, E_S2   = 13'h0080;
  localparam logic [12:0] E_S3   = 13'h0040, E_ADD  = 13'h0010, E_SUB  = 13'h0020;
  localparam logic [12:0] E_ACC  = 13'h0008, E_PC   = 13'h0004, E_HALT = 13'h0002;
  localparam logic [12:0] E_ERR  = 13'h0001, E_NONE = 13'h0000;

  ctrl_sequencer #(.OPW(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .o_imem_req(imem_req), .i_imem_ack(imem_ack), .i_instr(instr),
    .o_dmem_req(dmem_req), .o_dmem_we(dmem_we), .i_dmem_ack(dmem_ack),
    .i_zero_flag(zero_flag),
    .o_sel1(sel1), .o_sel2(sel2), .o_sel3(sel3), .o_alu_op(alu_op),
    .o_ir_we(ir_we), .o_acc_we(acc_we), .o_pc_en(pc_en), .o_halted(halted), .o_err(err)
  );

  assign obs = {imem_req, ir_we, dmem_req, dmem_we, sel1, sel2, sel3, alu_op,
                acc_we, pc_en, halted, err};

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reset, then land one cycle into FETCH (timeout counter = 0).
  task automatic go_fetch();
    rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; instr = 8'h00; zero_flag = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; instr = 8'h00; zero_flag = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (obs !== E_NONE) $display("FAIL reset_outs: got %h want %h", obs, E_NONE); else n_pass++;
    rst_n = 1'b1;
    imem_ack = 1'b1;  // ack while no request must be ignored
    #1;
    n_chk++; if (obs !== E_NONE) $display("FAIL idle_ack_ignored: got %h want %h", obs, E_NONE); else n_pass++;
    cyc();
    imem_ack = 1'b0;
    #1;
    n_chk++; if (obs !== E_IREQ) $display("FAIL idle_to_fetch: got %h want %h", obs, E_IREQ); else n_pass++;
  endtask

  task automatic test_alu();
    go_fetch();
    instr = 8'h21; imem_ack = 1'b1; #1;
    n_chk++; if (obs !== (E_IREQ | E_IRWE)) $display("FAIL addi_fetch: got %h want %h", obs, E_IREQ | E_IRWE); else n_pass++;
    cyc(); imem_ack = 1'b0; #1;
    n_chk++; if (obs !== E_NONE) $display("FAIL addi_decode: got %h want %h", obs, E_NONE); else n_pass++;
    cyc();
    n_chk++; if (obs !== (E_S2 | E_ADD | E_ACC | E_PC)) $display("FAIL addi_exec: got %h want %h", obs, E_S2 | E_ADD | E_ACC | E_PC); else n_pass++;
    cyc(); instr = 8'h30; imem_ack = 1'b1; #1;  // back-to-back SUB
    n_chk++; if (obs !== (E_IREQ | E_IRWE)) $display("FAIL sub_fetch: got %h want %h", obs, E_IREQ | E_IRWE); else n_pass++;
    cyc(); imem_ack = 1'b0; cyc();
    n_chk++; if (obs !== (E_SUB | E_ACC | E_PC)) $display("FAIL sub_exec: got %h want %h", obs, E_SUB | E_ACC | E_PC); else n_pass++;
  endtask

  task automatic test_ld();
    go_fetch();
    instr = 8'h53; imem_ack = 1'b1;
    cyc(); imem_ack = 1'b0; cyc();
    n_chk++; if (obs !== E_DREQ) $display("FAIL ld_mem1: got %h want %h", obs, E_DREQ); else n_pass++;
    cyc();
    n_chk++; if (obs !== E_DREQ) $display("FAIL ld_mem2: got %h want %h", obs, E_DREQ); else n_pass++;
    cyc(); dmem_ack = 1'b1; #1;
    n_chk++; if (obs !== E_DREQ) $display("FAIL ld_mem3_ack: got %h want %h", obs, E_DREQ); else n_pass++;
    cyc(); dmem_ack = 1'b0; #1;
    n_chk++; if (obs !== (E_S3 | E_ACC | E_PC)) $display("FAIL ld_wb: got %h want %h", obs, E_S3 | E_ACC | E_PC); else n_pass++;
    cyc();
    n_chk++; if (obs !== E_IREQ) $display("FAIL ld_refetch: got %h want %h", obs, E_IREQ); else n_pass++;
  endtask

  task automatic test_st();
    go_fetch();
    instr = 8'h60; imem_ack = 1'b1;
    cyc(); imem_ack = 1'b0; cyc();
    n_chk++; if (obs !== (E_DREQ | E_DWE)) $display("FAIL st_mem: got %h want %h", obs, E_DREQ | E_DWE); else n_pass++;
    dmem_ack = 1'b1; #1;
    n_chk++; if (obs !== (E_DREQ | E_DWE | E_PC)) $display("FAIL st_ack_pc: got %h want %h", obs, E_DREQ | E_DWE | E_PC); else n_pass++;
    cyc(); dmem_ack = 1'b0; #1;
    n_chk++; if (obs !== E_IREQ) $display("FAIL st_refetch: got %h want %h", obs, E_IREQ); else n_pass++;
  endtask

  task automatic test_jumps();
    go_fetch();
    zero_flag = 1'b1; instr = 8'h8A; imem_ack = 1'b1;
    cyc(); imem_ack = 1'b0; #1;
    n_chk++; if (obs !== (E_S1 | E_PC)) $display("FAIL jz_taken: got %h want %h", obs, E_S1 | E_PC); else n_pass++;
    cyc(); zero_flag = 1'b0; instr = 8'h8A; imem_ack = 1'b1;
    cyc(); imem_ack = 1'b0; #1;
    n_chk++; if (obs !== E_PC) $display("FAIL jz_not_taken: got %h want %h", obs, E_PC); else n_pass++;
    cyc(); instr = 8'h75; imem_ack = 1'b1;
    cyc(); imem_ack = 1'b0; #1;
    n_chk++; if (obs !== (E_S1 | E_PC)) $display("FAIL jmp: got %h want %h", obs, E_S1 | E_PC); else n_pass++;
  endtask

  task automatic test_timeout();
    logic [12:0] exp;
    go_fetch();
    for (int i = 1; i <= 8; i++) begin
      #1;
      exp = (i == 8) ? (E_IREQ | E_ERR) : E_IREQ;
      n_chk++; if (obs !== exp) $display("FAIL tmo_cycle%0d: got %h want %h", i, obs, exp); else n_pass++;
      cyc();
    end
    n_chk++; if (obs !== E_NONE) $display("FAIL tmo_req_drop: got %h want %h", obs, E_NONE); else n_pass++;
    cyc();
    n_chk++; if (obs !== E_IREQ) $display("FAIL tmo_refetch: got %h want %h", obs, E_IREQ); else n_pass++;
    for (int i = 1; i <= 7; i++) cyc();
    instr = 8'h00; imem_ack = 1'b1; #1;  // ack on the limit cycle wins
    n_chk++; if (obs !== (E_IREQ | E_IRWE)) $display("FAIL tmo_ack_wins: got %h want %h", obs, E_IREQ | E_IRWE); else n_pass++;
    cyc(); imem_ack = 1'b0; #1;
    n_chk++; if (obs !== E_PC) $display("FAIL nop_decode: got %h want %h", obs, E_PC); else n_pass++;
  endtask

  task automatic test_illegal_halt();
    go_fetch();
    instr = 8'hB0; imem_ack = 1'b1;
    cyc(); imem_ack = 1'b0; #1;
    n_chk++; if (obs !== (E_PC | E_ERR)) $display("FAIL illegal_decode: got %h want %h", obs, E_PC | E_ERR); else n_pass++;
    cyc();
    n_chk++; if (obs !== E_IREQ) $display("FAIL illegal_err_pulse: got %h want %h", obs, E_IREQ); else n_pass++;
    instr = 8'hF0; imem_ack = 1'b1;
    cyc(); imem_ack = 1'b0; #1;
    n_chk++; if (obs !== E_NONE) $display("FAIL halt_decode: got %h want %h", obs, E_NONE); else n_pass++;
    cyc();
    n_chk++; if (obs !== E_HALT) $display("FAIL halt_enter: got %h want %h", obs, E_HALT); else n_pass++;
    imem_ack = 1'b1; dmem_ack = 1'b1;
    repeat (3) cyc();
    n_chk++; if (obs !== E_HALT) $display("FAIL halt_absorb: got %h want %h", obs, E_HALT); else n_pass++;
    imem_ack = 1'b0; dmem_ack = 1'b0;
  endtask

  task automatic test_reset_mid_mem();
    go_fetch();
    instr = 8'h50; imem_ack = 1'b1;
    cyc(); imem_ack = 1'b0; cyc();
    n_chk++; if (obs !== E_DREQ) $display("FAIL rst_pre_mem: got %h want %h", obs, E_DREQ); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (obs !== E_NONE) $display("FAIL rst_async_drop: got %h want %h", obs, E_NONE); else n_pass++;
    @(posedge clk); #1 rst_n = 1'b1; #1;
    n_chk++; if (obs !== E_NONE) $display("FAIL rst_idle: got %h want %h", obs, E_NONE); else n_pass++;
    cyc();
    n_chk++; if (obs !== E_IREQ) $display("FAIL rst_refetch: got %h want %h", obs, E_IREQ); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu();
    test_ld();
    test_st();
    test_jumps();
    test_timeout();
    test_illegal_halt();
    test_reset_mid_mem();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
